// File: rtl/lsb_addr_queue.sv
// In-order address-result FIFO between the LSB address ALU and memory issue.
// Registered head outputs, registered backpressure with one slot of slack, sticky overflow flag.
module lsb_addr_queue #(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int ROB_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              _clear,
    input  logic              _lsb_ready,
    input  logic [ROB_W-1:0]  _lsb_rob_id,
    input  logic [DATA_W-1:0] _lsb_value,
    output logic              _lsb_full,
    output logic              _mem_valid,
    output logic [ROB_W-1:0]  _mem_rob_id,
    output logic [DATA_W-1:0] _mem_addr,
    input  logic              _mem_ack,
    output logic              _overflow
);

    localparam logic [PTR_W:0] DEPTH_C  = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0] FULL_THR = DEPTH_C - 1'b1;

    logic [ROB_W-1:0]  rob_mem_q  [DEPTH];
    logic [DATA_W-1:0] addr_mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;

    logic push, pop, push_ok;

    always_comb begin
        push       = _lsb_ready & rdy_in & ~_clear;
        pop        = (count_q != '0) & _mem_ack & rdy_in & ~_clear;
        push_ok    = push & ((count_q < DEPTH_C) | pop);

        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        full_d     = full_q;
        overflow_d = overflow_q;

        if (rdy_in) begin
            if (_clear) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                full_d  = 1'b0;
            end else begin
                if (pop)     head_d = head_q + PTR_W'(1);
                if (push_ok) tail_d = tail_q + PTR_W'(1);
                case ({push_ok, pop})
                    2'b10:   count_d = count_q + (PTR_W+1)'(1);
                    2'b01:   count_d = count_q - (PTR_W+1)'(1);
                    default: count_d = count_q;
                endcase
                // Threshold one below capacity gives the ALU a cycle to react.
                full_d = (count_d >= FULL_THR);
                if (push & ~push_ok) overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage is intentionally not reset; count gates visibility.
    always_ff @(posedge clk_in) begin
        if (push_ok && !rst_in) begin
            rob_mem_q[tail_q]  <= _lsb_rob_id;
            addr_mem_q[tail_q] <= _lsb_value;
        end
    end

    assign _lsb_full   = full_q;
    assign _overflow   = overflow_q;
    assign _mem_valid  = (count_q != '0);
    assign _mem_rob_id = rob_mem_q[head_q];
    assign _mem_addr   = addr_mem_q[head_q];

endmodule

// File: tb/tb_lsb_addr_queue.sv
// Randomized scoreboard bench for lsb_addr_queue; the reference is a plain queue of
// {rob_id, addr} with capacity 8, flushed by reset/clear.
module tb_lsb_addr_queue;

    localparam int DEPTH  = 8;
    localparam int ROB_W  = 5;
    localparam int DATA_W = 32;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              rdy_in = 1'b1;
    logic              _clear = 1'b0;
    logic              _lsb_ready = 1'b0;
    logic [ROB_W-1:0]  _lsb_rob_id = '0;
    logic [DATA_W-1:0] _lsb_value = '0;
    logic              _lsb_full;
    logic              _mem_valid;
    logic [ROB_W-1:0]  _mem_rob_id;
    logic [DATA_W-1:0] _mem_addr;
    logic              _mem_ack = 1'b0;
    logic              _overflow;

    lsb_addr_queue #(.DEPTH(DEPTH), .PTR_W(3), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        ._clear      (_clear),
        ._lsb_ready  (_lsb_ready),
        ._lsb_rob_id (_lsb_rob_id),
        ._lsb_value  (_lsb_value),
        ._lsb_full   (_lsb_full),
        ._mem_valid  (_mem_valid),
        ._mem_rob_id (_mem_rob_id),
        ._mem_addr   (_mem_addr),
        ._mem_ack    (_mem_ack),
        ._overflow   (_overflow)
    );

    always #5 clk_in = ~clk_in;

    typedef logic [ROB_W+DATA_W-1:0] entry_t;
    entry_t exp_q[$];
    logic   exp_ovf = 1'b0;
    int     checks = 0;
    int     errors = 0;
    bit     started = 1'b0;
    bit     done = 1'b0;

    typedef struct {
        int cycles;
        int p_push;
        int p_ack;
        int p_clear;
        int p_stall;
        int p_rst;
    } phase_t;

    phase_t phases[7];

    // Monitor: compares outputs at negedge; pops the reference on a handshake.
    always @(negedge clk_in) begin
        if (started && !done) begin
            checks++;
            if (_mem_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL mem_valid actual=%b required=%b", _mem_valid, exp_q.size() != 0);
            end
            checks++;
            if (_lsb_full !== (exp_q.size() >= DEPTH - 1)) begin
                errors++;
                $display("FAIL lsb_full actual=%b required=%b (entries=%0d)",
                         _lsb_full, exp_q.size() >= DEPTH - 1, exp_q.size());
            end
            checks++;
            if (_overflow !== exp_ovf) begin
                errors++;
                $display("FAIL overflow actual=%b required=%b", _overflow, exp_ovf);
            end
            if (exp_q.size() != 0) begin
                if (_mem_valid === 1'b1) begin
                    checks++;
                    if ({_mem_rob_id, _mem_addr} !== exp_q[0]) begin
                        errors++;
                        $display("FAIL head actual=%0h/%08h required=%0h/%08h", _mem_rob_id,
                                 _mem_addr, exp_q[0][ROB_W+DATA_W-1:DATA_W], exp_q[0][DATA_W-1:0]);
                    end
                end
                if (_mem_ack && rdy_in && !_clear && !rst_in) void'(exp_q.pop_front());
            end
        end
    end

    // Driver: at each posedge applies the cycle's effect to the reference, then drives new inputs.
    initial begin
        phases[0] = '{3,    0,   0,   0,  0,  100};
        phases[1] = '{20,   90,  0,   0,  0,  0};
        phases[2] = '{40,   100, 100, 0,  0,  0};
        phases[3] = '{1,    100, 100, 0,  0,  100};
        phases[4] = '{30,   70,  30,  0,  40, 0};
        phases[5] = '{1500, 60,  50,  5,  15, 1};
        phases[6] = '{20,   0,   100, 0,  0,  0};

        foreach (phases[p]) begin
            for (int c = 0; c < phases[p].cycles; c++) begin
                @(posedge clk_in);
                if (rst_in) begin
                    exp_q.delete();
                    exp_ovf = 1'b0;
                end else if (rdy_in) begin
                    if (_clear) exp_q.delete();
                    else if (_lsb_ready) begin
                        if (exp_q.size() < DEPTH) exp_q.push_back({_lsb_rob_id, _lsb_value});
                        else exp_ovf = 1'b1;
                    end
                end
                started = 1'b1;
                #2;
                rst_in      = ($urandom_range(99) < phases[p].p_rst);
                rdy_in      = !($urandom_range(99) < phases[p].p_stall);
                _clear      = ($urandom_range(99) < phases[p].p_clear);
                _lsb_ready  = ($urandom_range(99) < phases[p].p_push);
                _mem_ack    = ($urandom_range(99) < phases[p].p_ack);
                _lsb_rob_id = ROB_W'($urandom);
                _lsb_value  = $urandom;
            end
        end
        @(posedge clk_in);
        #2;
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
